bist_transmitter: RTL and testbench

//   Stimulus end of the link BIST: drives a PRBS pattern onto TEST_CHANNELS wires feeding the DUT/router link.
//   The pattern is bit-exact with what the far-end BIST receiver (same SEED) expects.

---
 rtl/bist_pkg.sv | 14 +
 rtl/bist_prbs32.sv | 26 ++
 rtl/bist_transmitter.sv | 112 +++++++++++
 tb/tb_bist_transmitter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and PRBS32 step function for the link BIST
package bist_pkg;

    typedef enum logic [1:0] {BIST_IDLE, BIST_RUN, BIST_DONE} bist_state_e;

    // x^32 + x^22 + x^2 + x + 1 expressed as state bit taps 31, 21, 1, 0
    localparam logic [31:0] PRBS_TAPS = 32'h8020_0003;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits
    function automatic logic [31:0] prbs32_next(input logic [31:0] s);
        return {s[30:0], ^(s & PRBS_TAPS)};
    endfunction

endpackage

// File: rtl/bist_prbs32.sv
// rtl/bist_prbs32.sv - single-step 32-bit PRBS generator with load and enable
module bist_prbs32
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] n
);

    logic [31:0] state;

    // Load has priority over stepping; the state holds when not enabled
    always_ff @(posedge clk) begin
        if (reset || load) begin
            state <= seed;
        end else if (en) begin
            state <= prbs32_next(state);
        end
    end

    assign n = state;

endmodule

// File: rtl/bist_transmitter.sv
// rtl/bist_transmitter.sv - link BIST pattern source with functional pass-through; optional BIST_TX_ERR_INJECT_EN
module bist_transmitter
    import bist_pkg::*;
#(
    parameter int unsigned TEST_CHANNELS = 70,
    parameter logic [31:0] SEED          = 32'hdeadbeef,
    parameter int unsigned TEST_CASES    = 1000,
    parameter int unsigned INJECT_CASE   = 500
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [TEST_CHANNELS-1:0] func_channels,
    output logic [TEST_CHANNELS-1:0] output_channels,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              case_count
);

    localparam logic [31:0] LAST_CASE = 32'(TEST_CASES) - 32'd1;

    bist_state_e              state;
    bist_state_e              state_next;
    logic                     accept;
    logic                     advance;
    logic [TEST_CHANNELS-1:0] pattern;
    logic [TEST_CHANNELS+31:0] pattern_wide;
    logic [31:0]              prbs_out;

    bist_prbs32 u_prbs (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (advance),
        .seed  (SEED),
        .n     (prbs_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BIST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus load/advance strobes; start is only honoured outside RUN
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        case (state)
            BIST_IDLE, BIST_DONE: begin
                if (start) begin
                    state_next = BIST_RUN;
                    accept     = 1'b1;
                end
            end
            BIST_RUN: begin
                if (TEST_CASES == 0) begin
                    state_next = BIST_DONE;
                end else begin
                    advance = 1'b1;
                    if (case_count == LAST_CASE) begin
                        state_next = BIST_DONE;
                    end
                end
            end
            default: state_next = BIST_IDLE;
        endcase
    end

    // New PRBS word enters at the bottom; older words slide up and fall off the top
    assign pattern_wide = {pattern, 32'd0} | {{TEST_CHANNELS{1'b0}}, prbs_out};

    // Pattern shift register and word counter
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            pattern    <= '0;
            case_count <= '0;
        end else if (advance) begin
            pattern    <= pattern_wide[TEST_CHANNELS-1:0];
            case_count <= case_count + 32'd1;
        end
    end

    assign busy = (state == BIST_RUN);
    assign done = (state == BIST_DONE);

`ifdef BIST_TX_ERR_INJECT_EN
    logic inject_hit;
    assign inject_hit = (INJECT_CASE < TEST_CASES) && (case_count == 32'(INJECT_CASE));
`else
    logic [31:0] unused_inject_case;
    assign unused_inject_case = 32'(INJECT_CASE);
`endif

    // Link drive: registered pattern while testing, functional traffic otherwise
    always_comb begin
        output_channels = func_channels;
        if (state == BIST_RUN) begin
            output_channels = pattern;
`ifdef BIST_TX_ERR_INJECT_EN
            if (inject_hit) begin
                output_channels[0] = ~pattern[0];
            end
`endif
        end
    end

endmodule

// File: tb/tb_bist_transmitter.sv
// tb/tb_bist_transmitter.sv - scoreboard bench for bist_transmitter
module tb_bist_transmitter;

    localparam int unsigned W           = 70;
    localparam int unsigned TEST_CASES  = 4;
    localparam int unsigned INJECT_CASE = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  func_channels;
    logic [W-1:0]  output_channels;
    logic          busy;
    logic          done;
    logic [31:0]   case_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] words[4];

    bist_transmitter #(
        .TEST_CHANNELS (W),
        .SEED          (32'hdeadbeef),
        .TEST_CASES    (TEST_CASES),
        .INJECT_CASE   (INJECT_CASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .func_channels   (func_channels),
        .output_channels (output_channels),
        .busy            (busy),
        .done            (done),
        .case_count      (case_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] w;
            w = words[i];
`ifdef BIST_TX_ERR_INJECT_EN
            if (i == int'(INJECT_CASE)) w[0] = ~w[0];
`endif
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done never rose within 20 cycles", name);
        end
    endtask

    // Monitor: every RUN cycle must present the next expected word
    always @(negedge clk) begin
        if (busy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got %h with no word expected", output_channels);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (output_channels !== e) begin
                    errors++;
                    $display("FAIL stream_word: got %h expected %h", output_channels, e);
                end
            end
        end
    end

    initial begin
        // Hand-derived stream for SEED=deadbeef: prbs1=bd5b7dde, prbs2=7ab6fbbc
        words[0] = 70'h0;
        words[1] = 70'h00_0000_0000_DEAD_BEEF;
        words[2] = 70'h00_DEAD_BEEF_BD5B_7DDE;
        words[3] = 70'h2F_BD5B_7DDE_7AB6_FBBC;

        reset         = 1'b1;
        start         = 1'b0;
        func_channels = 70'h3F_0123_4567_89AB_CDEF;
        repeat (3) step();
        check("reset_out", output_channels, 70'h3F_0123_4567_89AB_CDEF);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_count", W'(case_count), W'(0));
        reset = 1'b0;
        step();
        func_channels = 70'h15_5555_0000_FFFF_1234;
        #1;
        check("idle_pass", output_channels, 70'h15_5555_0000_FFFF_1234);

        // First run, with start re-pulsed mid-run (must be ignored)
        push_run(4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("run1_done");
        check("run1_busy", W'(busy), W'(0));
        check("run1_count", W'(case_count), W'(4));
        check("done_pass", output_channels, 70'h15_5555_0000_FFFF_1234);
        check("run1_drained", W'(exp_q.size()), W'(0));

        // Rerun from DONE produces the identical stream
        push_run(4);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rerun_busy", W'(busy), W'(1));
        check("rerun_done_clear", W'(done), W'(0));
        wait_done("run2_done");
        check("run2_count", W'(case_count), W'(4));

        // Abort after two words, then restart from word 0
        push_run(2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_count", W'(case_count), W'(0));
        check("abort_pass", output_channels, 70'h15_5555_0000_FFFF_1234);
        check("abort_drained", W'(exp_q.size()), W'(0));
        push_run(4);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("run3_done");
        check("run3_count", W'(case_count), W'(4));
        check("run3_drained", W'(exp_q.size()), W'(0));

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
